// File: rtl/signal_pkg.sv
// Shared types for the traffic-light sequencer: state/phase encoding and lamp decode.
package signal_pkg;

    localparam logic [2:0] PH_RED       = 3'd0;
    localparam logic [2:0] PH_RED_AMBER = 3'd1;
    localparam logic [2:0] PH_GREEN     = 3'd2;
    localparam logic [2:0] PH_AMBER     = 3'd3;
    localparam logic [2:0] PH_BLINK     = 3'd4;

    typedef enum logic [2:0] {
        ST_RED       = PH_RED,
        ST_RED_AMBER = PH_RED_AMBER,
        ST_GREEN     = PH_GREEN,
        ST_AMBER     = PH_AMBER,
        ST_BLINK     = PH_BLINK
    } state_t;

    typedef struct packed {
        logic red;
        logic amber;
        logic green;
    } lamps_t;

    function automatic lamps_t lamp_decode(state_t s, logic blink);
        lamps_t l;
        l = '0;
        case (s)
            ST_RED:       l.red = 1'b1;
            ST_RED_AMBER: begin
                l.red   = 1'b1;
                l.amber = 1'b1;
            end
            ST_GREEN:     l.green = 1'b1;
            ST_AMBER:     l.amber = 1'b1;
            ST_BLINK:     l.amber = blink;
            default:      l = '0;
        endcase
        return l;
    endfunction

    // Normal day cycle; BLINK falls back to RED.
    function automatic state_t next_in_cycle(state_t s);
        case (s)
            ST_RED:       return ST_RED_AMBER;
            ST_RED_AMBER: return ST_GREEN;
            ST_GREEN:     return ST_AMBER;
            default:      return ST_RED;
        endcase
    endfunction

endpackage

// File: rtl/signal_sequencer_tick_gen.sv
// Free-running prescaler: one-cycle tick every 2^WIDTH clocks, first tick 2^WIDTH-1 cycles after reset.
module tick_gen #(
    parameter int WIDTH = 17
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [WIDTH-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

    assign tick = &count;

endmodule

// File: rtl/signal_sequencer.sv
// Four-phase traffic-light controller with request-shortened green.
// Night blink mode is built only when SIGNAL_SEQ_BLINK_EN is defined.
module signal_sequencer #(
    parameter int TICK_BITS       = 17,
    parameter int DUR_BITS        = 8,
    parameter int RED_TICKS       = 200,
    parameter int RED_AMBER_TICKS = 40,
    parameter int GREEN_TICKS     = 200,
    parameter int AMBER_TICKS     = 60,
    parameter int MIN_GREEN_TICKS = 50,
    parameter int BLINK_TICKS     = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       night,
    output logic       ack,
    output logic       on_red,
    output logic       on_amber,
    output logic       on_green,
    output logic [2:0] phase
);

    import signal_pkg::*;

    logic                tick;
    state_t              state, nxt;
    logic                enter;
    logic                serve;
    logic                pending;
    logic [DUR_BITS-1:0] dwell;
    logic [DUR_BITS-1:0] elapsed;
    logic                blink_n;

    function automatic logic [DUR_BITS-1:0] dwell_load(state_t s);
        case (s)
            ST_RED_AMBER: return DUR_BITS'(RED_AMBER_TICKS - 1);
            ST_GREEN:     return DUR_BITS'(GREEN_TICKS - 1);
            ST_AMBER:     return DUR_BITS'(AMBER_TICKS - 1);
            default:      return DUR_BITS'(RED_TICKS - 1);
        endcase
    endfunction

    tick_gen #(.WIDTH(TICK_BITS)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        nxt   = state;
        enter = 1'b0;
        if (tick) begin
`ifdef SIGNAL_SEQ_BLINK_EN
            if (night) begin
                nxt   = ST_BLINK;
                enter = (state != ST_BLINK);
            end else if (state == ST_BLINK) begin
                nxt   = ST_RED;
                enter = 1'b1;
            end else
`endif
            if (state == ST_GREEN && pending &&
                elapsed >= DUR_BITS'(MIN_GREEN_TICKS)) begin
                nxt   = ST_AMBER;
                enter = 1'b1;
            end else if (dwell == '0) begin
                nxt   = next_in_cycle(state);
                enter = 1'b1;
            end
        end
    end

    assign serve = enter && (nxt == ST_RED) && pending;

`ifdef SIGNAL_SEQ_BLINK_EN
    logic                blink;
    logic [DUR_BITS-1:0] blink_cnt, blink_cnt_n;

    // Blink starts lit on entry and toggles after each BLINK_TICKS run of ticks.
    always_comb begin
        blink_n     = blink;
        blink_cnt_n = blink_cnt;
        if (enter && nxt == ST_BLINK) begin
            blink_n     = 1'b1;
            blink_cnt_n = DUR_BITS'(BLINK_TICKS - 1);
        end else if (tick && state == ST_BLINK && nxt == ST_BLINK) begin
            if (blink_cnt == '0) begin
                blink_n     = ~blink;
                blink_cnt_n = DUR_BITS'(BLINK_TICKS - 1);
            end else begin
                blink_cnt_n = blink_cnt - DUR_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            blink     <= blink_n;
            blink_cnt <= blink_cnt_n;
        end
    end
`else
    logic unused_night;
    assign unused_night = night;
    assign blink_n      = 1'b0;
`endif

    // Outputs are registered from the next state so lamps, phase and ack move on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RED;
            dwell    <= DUR_BITS'(RED_TICKS - 1);
            elapsed  <= '0;
            pending  <= 1'b0;
            ack      <= 1'b0;
            phase    <= PH_RED;
            on_red   <= 1'b1;
            on_amber <= 1'b0;
            on_green <= 1'b0;
        end else begin
            state <= nxt;
            phase <= nxt;
            {on_red, on_amber, on_green} <= lamp_decode(nxt, blink_n);

            if (enter) begin
                dwell <= dwell_load(nxt);
            end else if (tick && dwell != '0) begin
                dwell <= dwell - DUR_BITS'(1);
            end

            if (enter && nxt == ST_GREEN) begin
                elapsed <= '0;
            end else if (tick && state == ST_GREEN && elapsed != '1) begin
                elapsed <= elapsed + DUR_BITS'(1);
            end

            // A request arriving on the serving edge survives the clear.
            ack     <= serve;
            pending <= req | (pending & ~serve);
        end
    end

endmodule
